mem_responder: RTL and testbench

Memory-side responder for the processor's unified memory bus. It accepts the `proc2mem_command`/`proc2mem_addr`/`proc2mem_data` requests the pipeline issues, and answers each accepted request with a nonzero `mem2proc_response` tag in the same cycle. Each load's 64-bit line comes back on `mem2proc_data` with a matching `mem2proc_tag` a fixed number of cycles later. It replaces the behavioural memory in the testbench and is the synthesizable memory model for pipeline-level verification.

---
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - synthesizable memory responder: tagged loads with fixed latency, immediate stores
module mem_responder #(
   parameter int MEM_LINES       = 1024,
   parameter int LATENCY         = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int XLEN            = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      proc2mem_command,
   input  logic [XLEN-1:0] proc2mem_addr,
   input  logic [63:0]     proc2mem_data,
   output logic [3:0]      mem2proc_response,
   output logic [63:0]     mem2proc_data,
   output logic [3:0]      mem2proc_tag
);
   localparam int         IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   logic [63:0]     mem [MEM_LINES];
   logic [3:0]      next_tag_q, next_tag_d;
   logic [3:0]      outstanding_q, outstanding_d;
   logic [3:0]      tag_q [LATENCY];
   logic [63:0]     data_q [LATENCY];

   logic [XLEN-1:0] line_full;
   logic [IDX_W-1:0] line_idx;
   logic            in_range;
   logic            is_load;
   logic            is_store;
   logic            ret;
   logic            accept;
   logic            load_acc;
   logic            store_acc;
   logic            unused_addr_bits;

   assign line_full        = {3'b000, proc2mem_addr[XLEN-1:3]};
   assign line_idx         = line_full[IDX_W-1:0];
   assign in_range         = line_full < XLEN'(MEM_LINES);
   assign unused_addr_bits = ^proc2mem_addr[2:0];

   // A nonzero tag in the last stage marks a return; zero tags fill empty slots.
   assign ret = tag_q[LATENCY-1] != 4'd0;

   always_comb begin
      is_load       = 1'b0;
      is_store      = 1'b0;
      accept        = 1'b0;
      load_acc      = 1'b0;
      store_acc     = 1'b0;
      next_tag_d    = next_tag_q;
      outstanding_d = outstanding_q;

      is_load  = proc2mem_command == BUS_LOAD;
      is_store = proc2mem_command == BUS_STORE;
      // A same-cycle return frees its slot for the incoming load.
      accept   = reset && in_range &&
                 (is_store || (is_load && ((outstanding_q < 4'(MAX_OUTSTANDING)) || ret)));
      load_acc  = accept && is_load;
      store_acc = accept && is_store;

      if (accept) begin
         next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
      end
      outstanding_d = outstanding_q + {3'b000, load_acc} - {3'b000, ret};
   end

   assign mem2proc_response = accept ? next_tag_q : 4'd0;
   assign mem2proc_tag      = tag_q[LATENCY-1];
   assign mem2proc_data     = data_q[LATENCY-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         next_tag_q    <= 4'd1;
         outstanding_q <= 4'd0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i]  <= 4'd0;
            data_q[i] <= 64'd0;
         end
      end else begin
         next_tag_q    <= next_tag_d;
         outstanding_q <= outstanding_d;
         tag_q[0]      <= load_acc ? next_tag_q : 4'd0;
         data_q[0]     <= load_acc ? mem[line_idx] : 64'd0;
         for (int i = 1; i < LATENCY; i++) begin
            tag_q[i]  <= tag_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   // Backing store is deliberately not reset; the read above snapshots the line at request time.
   always_ff @(posedge clock) begin
      if (store_acc) begin
         mem[line_idx] <= proc2mem_data;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a queue-based memory model
module tb_mem_responder;
   localparam int MEM_LINES = 1024;
   localparam int LATENCY   = 8;
   localparam int MAX_OUT   = 4;

   logic        clock;
   logic        reset;
   logic [1:0]  cmd;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [3:0]  resp;
   logic [63:0] rdata;
   logic [3:0]  rtag;

   mem_responder #(
      .MEM_LINES(MEM_LINES), .LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUT), .XLEN(32)
   ) dut (
      .clock(clock), .reset(reset),
      .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
      .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(rtag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [63:0] data;
      bit          known;
   } pend_t;

   typedef struct {
      int          c;
      logic [3:0]  tag;
      logic [63:0] data;
   } ret_t;

   pend_t       pend[$];
   ret_t        rlog[$];
   logic [63:0] mm [int];
   logic [3:0]  m_tag = 4'd1;

   always @(negedge clock) begin
      logic        r;
      logic        acc;
      logic [3:0]  et;
      logic [63:0] ed;
      logic [3:0]  er;
      int          line;
      if (!reset) begin
         pend.delete();
         m_tag = 4'd1;
         check("rst_resp", resp, 4'd0);
         check("rst_tag", rtag, 4'd0);
         check("rst_data", rdata, 64'd0);
      end else begin
         r    = (pend.size() > 0) && (pend[0].due == cyc);
         et   = r ? pend[0].tag : 4'd0;
         ed   = r ? pend[0].data : 64'd0;
         line = int'(addr >> 3);
         acc  = (line < MEM_LINES) &&
                ((cmd == 2'd2) || ((cmd == 2'd1) && ((pend.size() < MAX_OUT) || r)));
         er   = acc ? m_tag : 4'd0;
         check("resp", resp, er);
         check("tag", rtag, et);
         if (!r || pend[0].known) check("data", rdata, ed);
         if (r) void'(pend.pop_front());
         if (acc) begin
            if (cmd == 2'd2) mm[line] = wdata;
            else pend.push_back('{cyc + LATENCY, m_tag,
                                  mm.exists(line) ? mm[line] : 64'd0, mm.exists(line)});
            m_tag = (m_tag == 4'd15) ? 4'd1 : m_tag + 4'd1;
         end
      end
      if (rtag != 4'd0) rlog.push_back('{cyc, rtag, rdata});
   end

   task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                        input int exp_resp, input string nm, output int at);
      @(posedge clock);
      #1;
      cmd = c; addr = a; wdata = d;
      at = cyc;
      @(negedge clock);
      if (exp_resp >= 0) check(nm, resp, exp_resp[3:0]);
   endtask

   task automatic idle(input int n);
      int t;
      repeat (n) drive(2'd0, 32'd0, 64'd0, -1, "idle", t);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b0; cmd = 2'd0;
      @(negedge clock);
      check("rstlit_tag", rtag, 4'd0);
      check("rstlit_data", rdata, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic check_ret(input string nm, input int idx, input int c,
                            input logic [3:0] tag, input logic [63:0] data);
      if (idx < rlog.size()) begin
         check({nm, "_cyc"}, rlog[idx].c, c);
         check({nm, "_tag"}, rlog[idx].tag, tag);
         check({nm, "_data"}, rlog[idx].data, data);
      end else begin
         check({nm, "_missing"}, 0, 1);
      end
   endtask

   localparam logic [63:0] DA = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] A  = 64'h1111_2222_3333_4444;
   localparam logic [63:0] B  = 64'h5555_6666_7777_8888;

   initial begin
      int t, c0, c1, c2;
      reset = 1'b0; cmd = 2'd0; addr = 32'd0; wdata = 64'd0;
      repeat (3) @(negedge clock);
      check("init_resp", resp, 4'd0);
      check("init_tag", rtag, 4'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // store then load
      rlog.delete();
      drive(2'd2, 32'h100, DA, 1, "sl_store", t);
      drive(2'd1, 32'h100, 64'd0, 2, "sl_load", c0);
      idle(12);
      check("sl_count", rlog.size(), 1);
      check_ret("sl_ret", 0, c0 + 8, 4'd2, DA);

      // outstanding limit
      do_reset();
      rlog.delete();
      for (int i = 0; i < 9; i++) begin
         drive(2'd1, 32'h100, 64'd0, (i < 4) ? i + 1 : ((i == 8) ? 5 : 0), "ol_resp", t);
         if (i == 0) c0 = t;
      end
      idle(12);
      check("ol_count", rlog.size(), 5);
      for (int i = 0; i < 4; i++) check_ret("ol_ret", i, c0 + 8 + i, 4'(i + 1), DA);
      check_ret("ol_ret5", 4, c0 + 16, 4'd5, DA);

      // tag wrap
      do_reset();
      for (int i = 0; i < 16; i++)
         drive(2'd2, 32'(i * 8), 64'(100 + i), (i < 15) ? i + 1 : 1, "wrap_resp", t);

      // snapshot semantics
      rlog.delete();
      drive(2'd2, 32'h200, A, 2, "sn_storeA", t);
      drive(2'd1, 32'h200, 64'd0, 3, "sn_load1", c1);
      drive(2'd2, 32'h200, B, 4, "sn_storeB", t);
      drive(2'd1, 32'h200, 64'd0, 5, "sn_load2", c2);
      idle(10);
      check("sn_count", rlog.size(), 2);
      check_ret("sn_ret1", 0, c1 + 8, 4'd3, A);
      check_ret("sn_ret2", 1, c2 + 8, 4'd5, B);

      // out of range and top in-range line
      rlog.delete();
      drive(2'd1, 32'(MEM_LINES * 8), 64'd0, 0, "oor_load", t);
      drive(2'd2, 32'(MEM_LINES * 8), 64'hBAD, 0, "oor_store", t);
      drive(2'd1, 32'h0, 64'd0, 6, "oor_line0", c1);
      drive(2'd2, 32'(MEM_LINES * 8 - 8), 64'hABCD, 7, "top_store", t);
      drive(2'd1, 32'(MEM_LINES * 8 - 8), 64'd0, 8, "top_load", c2);
      drive(2'd3, 32'h100, 64'd0, 0, "cmd3", t);
      idle(10);
      check("oor_count", rlog.size(), 2);
      check_ret("oor_ret", 0, c1 + 8, 4'd6, 64'd100);
      check_ret("top_ret", 1, c2 + 8, 4'd8, 64'hABCD);

      // reset mid-flight
      do_reset();
      rlog.delete();
      drive(2'd1, 32'h100, 64'd0, 1, "mf_load1", t);
      drive(2'd1, 32'h100, 64'd0, 2, "mf_load2", t);
      drive(2'd1, 32'h100, 64'd0, 3, "mf_load3", t);
      idle(2);
      do_reset();
      idle(12);
      check("mf_noret", rlog.size(), 0);
      drive(2'd2, 32'h100, DA, 1, "mf_after", t);
      idle(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
